// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction-fetch buffer between fetch and backend.
// An offered fetch entry is either consumed, or rejected with a replay
// request. After a rejection the queue waits for the fetch unit to re-offer
// the rejected address and drops any other entries until then.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 discard all entries and replay state
//   valid_i, instr_i, addr_i, cf_type_i, predict_addr_i, ex_i
//                           offered fetch entry
//   ready_o, almost_full_o  occupancy status (from registered count)
//   consumed_o, replay_o    same-cycle accept / reject of the offered entry
//   replay_addr_o           address to refetch
//   count_o                 occupancy
//   out_valid_o, out_ready_i, out_*_o
//                           head entry handshake and fields
module fetch_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned VLEN      = 64,
  parameter int unsigned ILEN      = 32,
  parameter int unsigned CF_W      = 3,
  parameter int unsigned EX_W      = 2,
  parameter int unsigned AF_MARGIN = 2,
  parameter int unsigned FULL_PASS = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [ILEN-1:0]            instr_i,
  input  logic [VLEN-1:0]            addr_i,
  input  logic [CF_W-1:0]            cf_type_i,
  input  logic [VLEN-1:0]            predict_addr_i,
  input  logic [EX_W-1:0]            ex_i,
  output logic                       ready_o,
  output logic                       almost_full_o,
  output logic                       consumed_o,
  output logic                       replay_o,
  output logic [VLEN-1:0]            replay_addr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ILEN-1:0]            out_instr_o,
  output logic [VLEN-1:0]            out_addr_o,
  output logic [CF_W-1:0]            out_cf_type_o,
  output logic [VLEN-1:0]            out_predict_addr_o,
  output logic [EX_W-1:0]            out_ex_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {NORMAL, REPLAY_WAIT} state_e;

  state_e            state_q, state_d;
  logic [VLEN-1:0]   replay_addr_q, replay_addr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ILEN-1:0]   instr_mem [DEPTH];
  logic [VLEN-1:0]   addr_mem  [DEPTH];
  logic [CF_W-1:0]   cf_mem    [DEPTH];
  logic [VLEN-1:0]   pred_mem  [DEPTH];
  logic [EX_W-1:0]   ex_mem    [DEPTH];

  logic pop, space, offer, push, reject;

  // Pop is suppressed during flush; FULL_PASS lets a push reuse the slot
  // freed by a same-cycle pop.
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign space       = (count_q < CNT_W'(DEPTH)) | ((FULL_PASS != 0) & pop);
  // In REPLAY_WAIT only the re-offered replay address is considered at all.
  assign offer       = valid_i & ~flush_i & ~rst_i &
                       ((state_q == NORMAL) | (addr_i == replay_addr_q));
  assign push        = offer & space;
  assign reject      = offer & ~space;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= NORMAL;
      replay_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      replay_addr_q <= replay_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    replay_addr_d = replay_addr_q;
    if (flush_i) begin
      state_d = NORMAL;
    end else begin
      unique case (state_q)
        NORMAL: begin
          if (reject) begin
            state_d       = REPLAY_WAIT;
            replay_addr_d = addr_i;
          end
        end
        REPLAY_WAIT: begin
          if (push) state_d = NORMAL;
          else if (reject) replay_addr_d = addr_i;
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  // Output logic
  always_comb begin
    consumed_o    = push;
    replay_o      = reject;
    replay_addr_o = reject ? addr_i : replay_addr_q;
  end

  // Pointers and occupancy
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= instr_i;
      addr_mem[wr_ptr_q]  <= addr_i;
      cf_mem[wr_ptr_q]    <= cf_type_i;
      pred_mem[wr_ptr_q]  <= predict_addr_i;
      ex_mem[wr_ptr_q]    <= ex_i;
    end
  end

  assign out_instr_o        = instr_mem[rd_ptr_q];
  assign out_addr_o         = addr_mem[rd_ptr_q];
  assign out_cf_type_o      = cf_mem[rd_ptr_q];
  assign out_predict_addr_o = pred_mem[rd_ptr_q];
  assign out_ex_o           = ex_mem[rd_ptr_q];

  assign count_o       = count_q;
  assign ready_o       = (count_q < CNT_W'(DEPTH));
  assign almost_full_o = (count_q >= CNT_W'(DEPTH - AF_MARGIN));

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: two instances (FULL_PASS=1 and FULL_PASS=0)
// share stimulus; each is compared every cycle against a queue-based model.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;

  logic        clk = 1'b0;
  logic        rst, flush, valid, out_ready;
  logic [31:0] instr;
  logic [63:0] addr, pa;
  logic [2:0]  cf;
  logic [1:0]  ex;

  logic        r0, af0, c0, rp0, ov0, r1, af1, c1, rp1, ov1;
  logic [63:0] ra0, oa0, opa0, ra1, oa1, opa1;
  logic [3:0]  cnt0, cnt1;
  logic [31:0] oi0, oi1;
  logic [2:0]  ocf0, ocf1;
  logic [1:0]  oex0, oex1;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .AF_MARGIN(AFM), .FULL_PASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid),
    .instr_i(instr), .addr_i(addr), .cf_type_i(cf), .predict_addr_i(pa), .ex_i(ex),
    .ready_o(r0), .almost_full_o(af0), .consumed_o(c0), .replay_o(rp0),
    .replay_addr_o(ra0), .count_o(cnt0), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_instr_o(oi0), .out_addr_o(oa0), .out_cf_type_o(ocf0),
    .out_predict_addr_o(opa0), .out_ex_o(oex0));

  fetch_queue #(.DEPTH(DEPTH), .AF_MARGIN(AFM), .FULL_PASS(0)) dut_np (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid),
    .instr_i(instr), .addr_i(addr), .cf_type_i(cf), .predict_addr_i(pa), .ex_i(ex),
    .ready_o(r1), .almost_full_o(af1), .consumed_o(c1), .replay_o(rp1),
    .replay_addr_o(ra1), .count_o(cnt1), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_instr_o(oi1), .out_addr_o(oa1), .out_cf_type_o(ocf1),
    .out_predict_addr_o(opa1), .out_ex_o(oex1));

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] instr;
    logic [2:0]  cf;
    logic [63:0] pa;
    logic [1:0]  ex;
  } ent_t;

  // Model: per instance an entry queue, a waiting flag and the awaited address.
  ent_t        mq0[$];
  ent_t        mq1[$];
  bit          mwait[2];
  logic [63:0] mlat[2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [63:0] a, input bit orr, input bit fl);
    valid     = v;
    addr      = a;
    instr     = $urandom;
    cf        = 3'($urandom);
    pa        = {$urandom, $urandom};
    ex        = 2'($urandom);
    out_ready = orr;
    flush     = fl;
    #1;
  endtask

  task automatic model_inst(input int k);
    ent_t q[$];
    logic c, rp, rdy, af, ov;
    logic [63:0] ra;
    logic [3:0] cnt;
    ent_t head, e;
    int n;
    bit pop, space, match, acc, rej;
    if (k == 0) begin
      q = mq0; c = c0; rp = rp0; ra = ra0; cnt = cnt0; rdy = r0; af = af0; ov = ov0;
      head = {oa0, oi0, ocf0, opa0, oex0};
    end else begin
      q = mq1; c = c1; rp = rp1; ra = ra1; cnt = cnt1; rdy = r1; af = af1; ov = ov1;
      head = {oa1, oi1, ocf1, opa1, oex1};
    end
    n = q.size();
    if (rst) begin
      check_eq($sformatf("rst_consumed%0d", k), c, 0);
      check_eq($sformatf("rst_replay%0d", k), rp, 0);
      check_eq($sformatf("rst_count%0d", k), cnt, 0);
      check_eq($sformatf("rst_out_valid%0d", k), ov, 0);
      check_eq($sformatf("rst_ready%0d", k), rdy, 1);
      check_eq($sformatf("rst_almost_full%0d", k), af, 0);
      check_eq($sformatf("rst_replay_addr%0d", k), ra, 0);
      q.delete();
      mwait[k] = 1'b0;
      mlat[k]  = '0;
    end else begin
      pop   = (n > 0) && out_ready && !flush;
      space = (n < DEPTH) || ((k == 0) && pop);
      match = valid && (!mwait[k] || (addr == mlat[k]));
      acc   = !flush && match && space;
      rej   = !flush && match && !space;
      check_eq($sformatf("consumed%0d", k), c, acc);
      check_eq($sformatf("replay%0d", k), rp, rej);
      check_eq($sformatf("replay_addr%0d", k), ra, rej ? addr : mlat[k]);
      check_eq($sformatf("count%0d", k), cnt, n);
      check_eq($sformatf("ready%0d", k), rdy, n < DEPTH);
      check_eq($sformatf("almost_full%0d", k), af, n >= DEPTH - AFM);
      check_eq($sformatf("out_valid%0d", k), ov, n != 0);
      if (n != 0) check_eq($sformatf("head%0d", k), head, q[0]);
      if (flush) begin
        q.delete();
        mwait[k] = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          e = '{addr: addr, instr: instr, cf: cf, pa: pa, ex: ex};
          q.push_back(e);
          mwait[k] = 1'b0;
        end
        if (rej) begin
          mwait[k] = 1'b1;
          mlat[k]  = addr;
        end
      end
    end
    if (k == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic step();
    model_inst(0);
    model_inst(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, '0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fill(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1, base + 64'(4 * i), 0, 0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, 0, 0);
    step();
    rst = 1'b0;

    // Fill to full with almost-full tracking, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 64'h1000 + 64'(4 * i), 0, 0);
      check_eq("af_fill", af0, i >= DEPTH - AFM);
      step();
    end
    drive(0, '0, 0, 0);
    check_eq("full_count", cnt0, 8);
    check_eq("full_ready", r0, 0);
    check_eq("full_af", af0, 1);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, '0, 1, 0);
      check_eq("drain_addr", oa0, 64'h1000 + 64'(4 * i));
      step();
    end

    // Replay on full, drop non-matching, accept the re-offer after a pop.
    do_reset();
    fill(DEPTH, 64'h1000);
    drive(1, 64'h2000, 0, 0);
    check_eq("rw_replay", rp0, 1);
    check_eq("rw_replay_addr", ra0, 64'h2000);
    step();
    drive(1, 64'h2004, 0, 0);
    check_eq("rw_drop_consumed", c0, 0);
    check_eq("rw_drop_replay", rp0, 0);
    step();
    drive(0, '0, 1, 0);
    step();
    drive(1, 64'h2000, 0, 0);
    check_eq("rw_match_consumed", c0, 1);
    step();
    drive(0, '0, 1, 0);
    step();
    drive(1, 64'h3000, 0, 0);
    check_eq("rw_back_normal", c0, 1);
    step();

    // Full pass-through versus no pass-through.
    do_reset();
    fill(DEPTH, 64'h1000);
    drive(1, 64'h4000, 1, 0);
    check_eq("fp1_consumed", c0, 1);
    check_eq("fp0_replay", rp1, 1);
    step();
    drive(0, '0, 0, 0);
    check_eq("fp1_count", cnt0, 8);
    step();

    // Flush with 3 entries while waiting for a replay.
    do_reset();
    fill(DEPTH, 64'h1000);
    drive(1, 64'h5000, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 1, 0);
      step();
    end
    drive(1, 64'h5000, 1, 1);
    check_eq("flush_consumed", c0, 0);
    check_eq("flush_replay", rp0, 0);
    step();
    drive(0, '0, 0, 0);
    check_eq("flush_count", cnt0, 0);
    check_eq("flush_out_valid", ov0, 0);
    step();
    drive(1, 64'h6000, 0, 0);
    check_eq("flush_normal", c0, 1);
    step();

    // Interleaved push/pop across the wrap point.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 99) < 65, 64'h7000 + 64'(4 * i),
            $urandom_range(0, 99) < (i < 30 ? 35 : 60), 0);
      step();
    end

    // Asynchronous reset at count 5 while waiting for a replay.
    do_reset();
    fill(DEPTH, 64'h1000);
    drive(1, 64'h5000, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 0);
      step();
    end
    rst = 1'b1;
    drive(1, 64'h8000, 1, 0);
    check_eq("mid_rst_out_valid", ov0, 0);
    check_eq("mid_rst_count", cnt0, 0);
    step();
    rst = 1'b0;
    drive(1, 64'h8000, 0, 0);
    check_eq("post_rst_consumed", c0, 1);
    step();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] a;
      a = ($urandom_range(0, 99) < 40) ? mlat[0] : {32'h0, $urandom & 32'hFFFF_FFFC};
      rst = ($urandom_range(0, 999) < 5);
      drive($urandom_range(0, 99) < 70, a,
            $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70),
            $urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
